// File: rtl/mem_ctrl_core_pkg.sv
// mem_ctrl_core_pkg
//   Shared constants and types for the 256 x 8 memory subsystem.
//   ADDR_W / DATA_W / DEPTH size the array and the system bus.
//   state_t enumerates the controller sequence IDLE -> ACCESS [-> RDATA].
package mem_ctrl_core_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_ctrl_core_if.sv
// mem_ctrl_core_if
//   System-side command bus of the memory subsystem.
//   we_sys        : command type, 1 = write, 0 = read
//   cmd_valid_sys : command request
//   addr_sys      : command address
//   ready_sys     : controller idle and able to accept a command
//   data_sys      : shared bidirectional data bus (write data in, read data out)
//   Modport master is the command issuer, slave is the memory subsystem.
interface mem_ctrl_core_if;
  import mem_ctrl_core_pkg::*;

  logic              we_sys;
  logic              cmd_valid_sys;
  logic [ADDR_W-1:0] addr_sys;
  logic              ready_sys;
  wire  [DATA_W-1:0] data_sys;

  modport master (
    output we_sys,
    output cmd_valid_sys,
    output addr_sys,
    input  ready_sys,
    inout  data_sys
  );

  modport slave (
    input  we_sys,
    input  cmd_valid_sys,
    input  addr_sys,
    output ready_sys,
    inout  data_sys
  );

endinterface

// File: rtl/mem_array_256x8.sv
// mem_array_256x8
//   Single-port storage array with synchronous write and registered read.
//   clk   : clock
//   reset : asynchronous active-low clear of every word and of dout
//   ce    : access enable; nothing happens while low
//   we    : 1 = write din to addr, 0 = read addr into dout
//   addr  : word address
//   din   : write data
//   dout  : registered read data, holds its last value when not read
module mem_array_256x8
  import mem_ctrl_core_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q;

  // The whole array must read as zero after reset, so the clear is part of
  // the storage process rather than a separate initialisation sequence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      dout_q <= '0;
    end else if (ce) begin
      if (we) begin
        mem_q[addr] <= din;
      end else begin
        dout_q <= mem_q[addr];
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/mem_ctrl_core.sv
// mem_ctrl_core
//   Command-level controller plus 256 x 8 storage array.
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-low reset (FSM to IDLE, array cleared)
//   bus   : slave side of mem_ctrl_core_if (we/valid/addr in, ready out,
//           data_sys bidirectional; driven by this block only in RDATA)
//   Write: accept edge T0, stored at T1, ready back after T1.
//   Read : accept edge T0, array registers data at T1, data_sys valid
//          T1..T2, ready back after T2.
module mem_ctrl_core
  import mem_ctrl_core_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  mem_ctrl_core_if.slave   bus
);

  state_t            state_q;
  logic              ready_q;
  logic              ce_q;
  logic              we_q;
  logic              drive_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata;

  // ce/we/ready/drive are registered alongside the state so that each one
  // reflects the state the FSM is currently in, without decode glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      drive_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid_sys) begin
            state_q <= ACCESS;
            ready_q <= 1'b0;
            ce_q    <= 1'b1;
            we_q    <= bus.we_sys;
            addr_q  <= bus.addr_sys;
            // The master only drives the bus alongside a write command.
            if (bus.we_sys) begin
              wdata_q <= bus.data_sys;
            end
          end
        end
        ACCESS: begin
          // The array performs the access on this same edge.
          ce_q <= 1'b0;
          we_q <= 1'b0;
          if (we_q) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            state_q <= RDATA;
            drive_q <= 1'b1;
          end
        end
        RDATA: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          drive_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          ce_q    <= 1'b0;
          we_q    <= 1'b0;
          drive_q <= 1'b0;
        end
      endcase
    end
  end

  mem_array_256x8 u_array (
    .clk   (clk),
    .reset (reset),
    .ce    (ce_q),
    .we    (we_q),
    .addr  (addr_q),
    .din   (wdata_q),
    .dout  (rdata)
  );

  assign bus.ready_sys = ready_q;
  assign bus.data_sys  = drive_q ? rdata : 'z;

endmodule

// File: tb/tb_mem_ctrl_core.sv
// tb_mem_ctrl_core
//   Directed bench for mem_ctrl_core: reset behaviour, write/read latency,
//   boundary addresses, full sweep, ignored commands, back-to-back commands
//   and reset during a read access.
module tb_mem_ctrl_core;
  import mem_ctrl_core_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_ctrl_core_if bus ();

  logic              tb_drv;
  logic [DATA_W-1:0] tb_data;
  assign bus.data_sys = tb_drv ? tb_data : 'z;

  mem_ctrl_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Block must not be driving: with the master released, the bus must not
  // show the value the block would drive.
  task automatic chk_released(input string tag, input logic [DATA_W-1:0] val);
    chk(tag, {31'b0, (bus.data_sys === val)}, 32'd0);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    chk("wr_idle_before", {31'b0, bus.ready_sys}, 32'd1);
    bus.cmd_valid_sys = 1'b1;
    bus.we_sys        = 1'b1;
    bus.addr_sys      = a;
    tb_data           = d;
    tb_drv            = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_sys = 1'b0;
    bus.we_sys        = 1'b0;
    tb_drv            = 1'b0;
    chk("wr_ready_busy", {31'b0, bus.ready_sys}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("wr_ready_back", {31'b0, bus.ready_sys}, 32'd1);
    $display("write addr=0x%02h data=0x%02h", a, d);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    @(negedge clk);
    chk("rd_idle_before", {31'b0, bus.ready_sys}, 32'd1);
    bus.cmd_valid_sys = 1'b1;
    bus.we_sys        = 1'b0;
    bus.addr_sys      = a;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_sys = 1'b0;
    chk("rd_ready_busy1", {31'b0, bus.ready_sys}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    d = bus.data_sys;
    chk("rd_ready_busy2", {31'b0, bus.ready_sys}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rd_ready_back", {31'b0, bus.ready_sys}, 32'd1);
    $display("read  addr=0x%02h data=0x%02h", a, d);
  endtask

  task automatic chk_read(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    logic [DATA_W-1:0] d;
    do_read(a, d);
    chk(tag, {24'b0, d}, {24'b0, exp});
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    logic [ADDR_W-1:0] a;

    reset             = 1'b0;
    tb_drv            = 1'b0;
    tb_data           = '0;
    bus.cmd_valid_sys = 1'b0;
    bus.we_sys        = 1'b0;
    bus.addr_sys      = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset_ready", {31'b0, bus.ready_sys}, 32'd1);
    reset = 1'b1;

    // Reset pulsed mid-cycle while a write is in ACCESS.
    @(negedge clk);
    bus.cmd_valid_sys = 1'b1;
    bus.we_sys        = 1'b1;
    bus.addr_sys      = 8'h00;
    tb_data           = 8'h99;
    tb_drv            = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid_sys = 1'b0;
    bus.we_sys        = 1'b0;
    tb_drv            = 1'b0;
    chk("busy_before_reset", {31'b0, bus.ready_sys}, 32'd0);
    #2 reset = 1'b0;
    #1 chk("reset_mid_ready", {31'b0, bus.ready_sys}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    $display("reset pulse during write access");
    chk_read("reset_rd_00", 8'h00, 8'h00);
    chk_read("reset_rd_ff", 8'hFF, 8'h00);

    // Write then read with latency checks inside the tasks.
    do_write(8'h10, 8'hA5);
    chk_read("rd_10", 8'h10, 8'hA5);
    @(negedge clk);
    chk_released("bus_released_after_rd", 8'hA5);

    // Boundary addresses.
    do_write(8'h00, 8'h3C);
    do_write(8'hFF, 8'hC3);
    chk_read("rd_00", 8'h00, 8'h3C);
    chk_read("rd_ff", 8'hFF, 8'hC3);
    chk_read("rd_10_kept", 8'h10, 8'hA5);

    // Command presented while busy is ignored.
    do_write(8'h20, 8'h42);
    @(negedge clk);
    bus.cmd_valid_sys = 1'b1;
    bus.we_sys        = 1'b1;
    bus.addr_sys      = 8'h30;
    tb_data           = 8'h55;
    tb_drv            = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.addr_sys = 8'h20;
    tb_data      = 8'h77;
    chk("ign_ready_busy", {31'b0, bus.ready_sys}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_sys = 1'b0;
    bus.we_sys        = 1'b0;
    tb_drv            = 1'b0;
    chk("ign_ready_back", {31'b0, bus.ready_sys}, 32'd1);
    $display("write addr=0x30 data=0x55 with overlapping write to 0x20");
    chk_read("ign_rd_20", 8'h20, 8'h42);
    chk_read("ign_rd_30", 8'h30, 8'h55);

    // Back-to-back with cmd_valid_sys held high.
    @(negedge clk);
    bus.cmd_valid_sys = 1'b1;
    bus.we_sys        = 1'b1;
    bus.addr_sys      = 8'h01;
    tb_data           = 8'h11;
    tb_drv            = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_drv     = 1'b0;
    bus.we_sys = 1'b0;
    chk("b2b_wr_busy", {31'b0, bus.ready_sys}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_wr_back", {31'b0, bus.ready_sys}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_sys = 1'b0;
    chk("b2b_rd_busy1", {31'b0, bus.ready_sys}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_rd_busy2", {31'b0, bus.ready_sys}, 32'd0);
    chk("b2b_rd_data", {24'b0, bus.data_sys}, 32'h11);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_rd_back", {31'b0, bus.ready_sys}, 32'd1);
    chk_released("b2b_released", 8'h11);
    $display("back-to-back write 0x01=0x11 then read");

    // Full sweep.
    for (int i = 0; i < DEPTH; i++) begin
      a = i[ADDR_W-1:0];
      do_write(a, a ^ 8'h5A);
    end
    for (int i = 0; i < DEPTH; i++) begin
      a = i[ADDR_W-1:0];
      chk_read("sweep_rd", a, a ^ 8'h5A);
    end

    // Reset during ACCESS of a read to 0x10 (holds 0x4A); dout holds 0x5A.
    chk_read("pre_rst_rd_00", 8'h00, 8'h5A);
    @(negedge clk);
    bus.cmd_valid_sys = 1'b1;
    bus.we_sys        = 1'b0;
    bus.addr_sys      = 8'h10;
    @(posedge clk);
    #2;
    bus.cmd_valid_sys = 1'b0;
    reset             = 1'b0;
    #1;
    chk("rst_acc_ready", {31'b0, bus.ready_sys}, 32'd1);
    chk_released("rst_acc_bus_4a", 8'h4A);
    chk_released("rst_acc_bus_5a", 8'h5A);
    @(negedge clk);
    reset = 1'b1;
    $display("reset pulse during read access of 0x10");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_acc_idle", {31'b0, bus.ready_sys}, 32'd1);
      chk_released("rst_acc_bus_idle", 8'h4A);
    end
    for (int i = 0; i < DEPTH; i++) begin
      a = i[ADDR_W-1:0];
      chk_read("rst_acc_zero", a, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
